// File: rtl/vjtag_debug_initiator.sv
// System-clock virtual-JTAG master: runs one UIR/CDR/SHIFT/UDR/RTI scan per command
// against the debug slave and returns the tdo bits and sampled IR status.
module vjtag_debug_initiator #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  // strobe vector order: {rti, udr, sdr, cdr, uir}
  localparam logic [4:0] STB_UIR = 5'b00001;
  localparam logic [4:0] STB_CDR = 5'b00010;
  localparam logic [4:0] STB_SDR = 5'b00100;
  localparam logic [4:0] STB_UDR = 5'b01000;
  localparam logic [4:0] STB_RTI = 5'b10000;

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI} state_e;

  state_e              state_q;
  logic                ready_q, rsp_valid_q, phase_q, tck_q, tdi_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DR_WIDTH-1:0] sr_q, rsp_q;
  logic [IR_WIDTH-1:0] ir_q, irout_q;
  logic [4:0]          strb_q;
  logic                half_end;

  assign half_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      phase_q     <= 1'b0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      rsp_q       <= '0;
      ir_q        <= '0;
      irout_q     <= '0;
      strb_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (cmd_valid) begin
          state_q <= S_UIR;
          strb_q  <= STB_UIR;
          ready_q <= 1'b0;
          ir_q    <= cmd_ir;
          sr_q    <= cmd_data;
          div_q   <= '0;
          phase_q <= 1'b0;
          tck_q   <= 1'b0;
          bit_q   <= '0;
        end
      end else if (!half_end) begin
        div_q <= div_q + 1'b1;
      end else begin
        div_q   <= '0;
        phase_q <= ~phase_q;
        tck_q   <= ~phase_q;
        // end of a full tck period: sample and advance
        if (phase_q) begin
          case (state_q)
            S_UIR: begin
              state_q <= S_CDR;
              strb_q  <= STB_CDR;
            end
            S_CDR: begin
              state_q <= S_SHIFT;
              strb_q  <= STB_SDR;
              irout_q <= vji_ir_out;
              tdi_q   <= sr_q[0];
            end
            S_SHIFT: begin
              rsp_q[bit_q] <= vji_tdo;
              if (bit_q == BIT_LAST) begin
                bit_q   <= '0;
                state_q <= S_UDR;
                strb_q  <= STB_UDR;
                tdi_q   <= 1'b0;
              end else begin
                bit_q <= bit_q + 1'b1;
                sr_q  <= sr_q >> 1;
                tdi_q <= sr_q[1];
              end
            end
            S_UDR: begin
              state_q <= S_RTI;
              strb_q  <= STB_RTI;
            end
            S_RTI: begin
              state_q     <= S_IDLE;
              strb_q      <= '0;
              ready_q     <= 1'b1;
              rsp_valid_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = ~ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_q;
  assign rsp_ir_out = irout_q;
  assign vji_tck    = tck_q;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_q;
  assign {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir} = strb_q;
endmodule

// File: tb/tb_vjtag_debug_initiator.sv
// Bench for vjtag_debug_initiator: default-parameter instance for scan/reset tests and a
// TCK_DIV=1 instance for back-to-back commands; responses checked against a queue model.
module tb_vjtag_debug_initiator;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int strb_viol = 0, tdi_viol = 0, tck_viol = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // instance 0: defaults
  logic        u0_cv = 1'b0, u0_ready, u0_rv, u0_busy, u0_tck, u0_tdi, u0_tdo;
  logic [1:0]  u0_ir = '0, u0_irin, u0_irout = '0, u0_rirout;
  logic [37:0] u0_data = '0, u0_rdata;
  logic        u0_uir, u0_cdr, u0_sdr, u0_udr, u0_rti;
  // instance 1: TCK_DIV=1
  logic        u1_cv = 1'b0, u1_ready, u1_rv, u1_busy, u1_tck, u1_tdi, u1_tdo;
  logic [1:0]  u1_ir = '0, u1_irin, u1_irout = '0, u1_rirout;
  logic [37:0] u1_data = '0, u1_rdata;
  logic        u1_uir, u1_cdr, u1_sdr, u1_udr, u1_rti;

  vjtag_debug_initiator u0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(u0_cv), .cmd_ready(u0_ready), .cmd_ir(u0_ir),
    .cmd_data(u0_data), .rsp_valid(u0_rv), .rsp_data(u0_rdata), .rsp_ir_out(u0_rirout),
    .busy(u0_busy), .vji_tck(u0_tck), .vji_tdi(u0_tdi), .vji_tdo(u0_tdo), .vji_ir_in(u0_irin),
    .vji_ir_out(u0_irout), .vji_uir(u0_uir), .vji_cdr(u0_cdr), .vji_sdr(u0_sdr),
    .vji_udr(u0_udr), .vji_rti(u0_rti));

  vjtag_debug_initiator #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(u1_cv), .cmd_ready(u1_ready), .cmd_ir(u1_ir),
    .cmd_data(u1_data), .rsp_valid(u1_rv), .rsp_data(u1_rdata), .rsp_ir_out(u1_rirout),
    .busy(u1_busy), .vji_tck(u1_tck), .vji_tdi(u1_tdi), .vji_tdo(u1_tdo), .vji_ir_in(u1_irin),
    .vji_ir_out(u1_irout), .vji_uir(u1_uir), .vji_cdr(u1_cdr), .vji_sdr(u1_sdr),
    .vji_udr(u1_udr), .vji_rti(u1_rti));

  // slave model: tdo is tdi captured on the tck rising edge, or tied high
  logic tdo_mode = 1'b0, lb0 = 1'b0, lb1 = 1'b0;
  always @(posedge u0_tck) lb0 <= u0_tdi;
  always @(posedge u1_tck) lb1 <= u1_tdi;
  assign u0_tdo = tdo_mode ? 1'b1 : lb0;
  assign u1_tdo = lb1;

  logic [37:0] q0d[$], q1d[$];
  logic [1:0]  q0i[$], q1i[$];
  int          acc1[$], rsp1[$];

  // scoreboard push on accept
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && u0_cv && u0_ready) begin
      q0d.push_back(tdo_mode ? {38{1'b1}} : u0_data);
      q0i.push_back(u0_irout);
    end
    if (reset_n && u1_cv && u1_ready) begin
      q1d.push_back(u1_data);
      q1i.push_back(u1_irout);
      acc1.push_back(cyc);
    end
  end

  logic ptdi0 = 1'b0, pbusy1 = 1'b0, ptck1 = 1'b0;
  always @(negedge clk) begin
    if (u0_rv) begin
      chk("u0_ready_at_rsp", u0_ready, 1);
      chk("u0_rsp_expected", q0d.size() > 0, 1);
      if (q0d.size() > 0) begin
        chk("u0_rsp_data", u0_rdata, q0d.pop_front());
        chk("u0_rsp_ir", u0_rirout, q0i.pop_front());
      end
    end
    if (u1_rv) begin
      rsp1.push_back(cyc);
      chk("u1_ready_at_rsp", u1_ready, 1);
      chk("u1_rsp_expected", q1d.size() > 0, 1);
      if (q1d.size() > 0) begin
        chk("u1_rsp_data", u1_rdata, q1d.pop_front());
        chk("u1_rsp_ir", u1_rirout, q1i.pop_front());
      end
    end
    if (u0_busy ? !$onehot({u0_uir, u0_cdr, u0_sdr, u0_udr, u0_rti})
                : ({u0_uir, u0_cdr, u0_sdr, u0_udr, u0_rti} != 5'b0)) strb_viol++;
    if (u1_busy ? !$onehot({u1_uir, u1_cdr, u1_sdr, u1_udr, u1_rti})
                : ({u1_uir, u1_cdr, u1_sdr, u1_udr, u1_rti} != 5'b0)) strb_viol++;
    if (u0_tdi != ptdi0 && u0_tck) tdi_viol++;
    ptdi0 = u0_tdi;
    if (u1_busy && pbusy1 && u1_tck == ptck1) tck_viol++;
    if (!u1_busy && u1_tck) tck_viol++;
    pbusy1 = u1_busy;
    ptck1  = u1_tck;
  end

  // one full scan on u0 with timing and tdi-order checks
  task automatic scan0(input logic [1:0] ir, input logic [37:0] d, input bit mid);
    logic [37:0] obs;
    int k, lat, uf, ul, sc;
    logic pt;
    obs = '0; k = 0; lat = 0; uf = 0; ul = 0; sc = 0; pt = 1'b0;
    @(negedge clk);
    u0_cv = 1'b1; u0_ir = ir; u0_data = d;
    @(posedge clk);
    for (int c = 1; c <= 400 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        u0_cv = 1'b0;
        chk("ir_in_after_accept", u0_irin, ir);
      end
      if (mid && c >= 20 && c < 40) begin
        u0_cv = ~u0_cv;
        u0_data = ~d;
      end
      if (u0_uir) begin
        if (uf == 0) uf = c;
        ul = c;
      end
      if (u0_sdr) sc++;
      if (u0_sdr && u0_tck && !pt && k < 38) begin
        obs[k] = u0_tdi;
        k++;
      end
      pt = u0_tck;
      if (u0_rv) lat = c;
    end
    chk("rsp_latency", lat, 169);
    chk("uir_first_cycle", uf, 1);
    chk("uir_last_cycle", ul, 4);
    chk("sdr_cycles", sc, 152);
    chk("tdi_lsb_first", obs, d);
  endtask

  logic [63:0] tmp;
  int rvc;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {u0_ready, u0_busy, u0_rv, u0_tck, u0_tdi,
                        u0_uir, u0_cdr, u0_sdr, u0_udr, u0_rti}, 10'b1000000000);
    chk("rst_rsp_data", u0_rdata, 0);
    chk("rst_rsp_ir", u0_rirout, 0);
    chk("rst_ir_in", u0_irin, 0);
    reset_n = 1'b1;

    tdo_mode = 1'b0; u0_irout = 2'b11;
    scan0(2'b01, 38'h2A_5555_AAAA, 1'b0);

    tdo_mode = 1'b1; u0_irout = 2'b10;
    scan0(2'b10, 38'h15_0F0F_3C3C, 1'b0);
    @(negedge clk);
    chk("tied_rsp_data", u0_rdata, 38'h3F_FFFF_FFFF);
    chk("tied_rsp_ir", u0_rirout, 2'b10);

    tdo_mode = 1'b0; u0_irout = 2'b01;
    scan0(2'b11, 38'h01_2345_6789, 1'b1);

    // abort at SHIFT bit 20 (cycles 89..92 after accept)
    @(negedge clk);
    u0_cv = 1'b1; u0_ir = 2'b10; u0_data = 38'h2F_0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    u0_cv = 1'b0;
    repeat (89) @(negedge clk);
    chk("abort_in_shift", u0_sdr, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {u0_ready, u0_busy, u0_rv, u0_tck, u0_tdi,
                          u0_uir, u0_cdr, u0_sdr, u0_udr, u0_rti}, 10'b1000000000);
    chk("abort_rsp_data", u0_rdata, 0);
    q0d.delete(); q0i.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rvc = 0;
    repeat (200) begin
      @(negedge clk);
      if (u0_rv) rvc++;
    end
    chk("abort_no_rsp", rvc, 0);
    chk("abort_ready", u0_ready, 1);
    scan0(2'b01, 38'h3A_BCDE_F012, 1'b0);

    for (int i = 0; i < 3; i++) begin
      tdo_mode = 1'($urandom_range(0, 1));
      u0_irout = 2'($urandom_range(0, 3));
      tmp = {$urandom(), $urandom()};
      scan0(2'($urandom_range(0, 3)), tmp[37:0], 1'b0);
    end

    // TCK_DIV=1 back-to-back, command held valid
    u1_irout = 2'b01;
    @(negedge clk);
    u1_cv = 1'b1; u1_ir = 2'b10; u1_data = 38'h0F_1234_5678;
    for (int i = 0; i < 400 && acc1.size() < 2; i++) begin
      @(negedge clk);
      if (acc1.size() == 1) u1_data = 38'h30_8765_4321;
    end
    u1_cv = 1'b0;
    chk("b2b_accepts", acc1.size(), 2);
    for (int i = 0; i < 200 && rsp1.size() < 2; i++) @(negedge clk);
    chk("b2b_rsps", rsp1.size(), 2);
    if (acc1.size() == 2 && rsp1.size() == 2) begin
      chk("b2b_gap", acc1[1] - acc1[0], 85);
      chk("b2b_scan1_len", rsp1[0] - acc1[0], 84);
      chk("b2b_scan2_len", rsp1[1] - acc1[1], 84);
    end
    chk("b2b_ir_in", u1_irin, 2'b10);

    repeat (5) @(negedge clk);
    chk("strobe_onehot", strb_viol, 0);
    chk("tdi_only_tck_low", tdi_viol, 0);
    chk("tck_toggle_div1", tck_viol, 0);
    chk("q0_drained", q0d.size(), 0);
    chk("q1_drained", q1d.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
